// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by dmem_responder and its bus interface users.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_LSB      = 2;
    localparam int BYTE_OFFSET_W = 2;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_MISALIGN = 2'd2
    } err_cause_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, registered read (read-before-write).
// Contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one lw/sw at a time, fixed LATENCY, range error flag.
// Optional misaligned-address error enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int WIDX_W = ADDR_WIDTH - WORD_LSB;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    err_cause_e            cause_q, cause_d;
    logic                  we_q;
    logic [IDX_W-1:0]      idx_q;

    logic                  accept;
    logic [WIDX_W-1:0]     word_idx;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign word_idx = bus.req_addr[ADDR_WIDTH-1:WORD_LSB];

    // Range uses the full upper address bits, so large addresses never wrap.
    always_comb begin
        cause_d = ERR_NONE;
        if ({{WORD_LSB{1'b0}}, word_idx} >= ADDR_WIDTH'(DEPTH_WORDS)) begin
            cause_d = ERR_RANGE;
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        else if (bus.req_addr[BYTE_OFFSET_W-1:0] != '0) begin
            cause_d = ERR_MISALIGN;
        end
`endif
    end

`ifndef DMEM_MISALIGN_CHECK_EN
    logic unused_byte_offset;
    assign unused_byte_offset = ^bus.req_addr[BYTE_OFFSET_W-1:0];
`endif

    // The RAM is addressed by the incoming request on the accept edge, by the latch after.
    assign ram_we  = accept && bus.req_we && (cause_d == ERR_NONE);
    assign ram_idx = accept ? word_idx[IDX_W-1:0] : idx_q;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (bus.req_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cause_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cause_q <= cause_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q  <= bus.req_we;
            idx_q <= word_idx[IDX_W-1:0];
        end
    end

    // No writes occur outside IDLE, so the registered RAM output is stable through RESP.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && (cause_q != ERR_NONE);
    assign bus.rsp_rdata = ((state_q == RESP) && !we_q && (cause_q == ERR_NONE)) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2 and LATENCY=1 instances).
// Expectations follow DMEM_MISALIGN_CHECK_EN when it is defined.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic        MIS_ERR = 1'b1;
    localparam logic [31:0] EXP_W4  = 32'hDEADBEEF;
`else
    localparam logic        MIS_ERR = 1'b0;
    localparam logic [31:0] EXP_W4  = 32'h00000001;
`endif

    dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m  ();
    dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m2 ();

    dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (m2.slave)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request and returns just after the edge that accepts it.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        @(negedge clk);
        m.req_valid = 1'b1;
        m.req_we    = we;
        m.req_addr  = addr;
        m.req_wdata = wd;
        n = 0;
        while (!m.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("req_ready_timeout", m.req_ready, 1'b1);
        @(posedge clk);
        #1 m.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m.rsp_valid && lat < 20);
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        issue(we, addr, wd);
        wait_rsp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_err"}, m.rsp_err, exp_err);
        chk({tag, "_rdata"}, m.rsp_rdata, exp_rd);
        @(negedge clk);
        chk({tag, "_done"}, m.rsp_valid, 1'b0);
    endtask

    initial begin
        int lat;
        int k;
        int n;
        int acc[4];
        logic rdy;

        rst = 1'b1;
        m.req_valid = 1'b0;  m.req_we = 1'b0;  m.req_addr = '0;  m.req_wdata = '0;  m.rsp_ready = 1'b1;
        m2.req_valid = 1'b0; m2.req_we = 1'b0; m2.req_addr = '0; m2.req_wdata = '0; m2.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", m.req_ready, 1'b1);
        chk("rst_rsp_valid", m.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", m.rsp_rdata, 32'h0);
        chk("rst_rsp_err",   m.rsp_err,   1'b0);
        chk("rst_busy",      m.busy,      1'b0);
        chk("rst_req_ready2", m2.req_ready, 1'b1);
        rst = 1'b0;

        // Store, then load back with the response held off for five cycles
        txn("t1_sw", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);

        m.rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0);
        wait_rsp(lat);
        chk("t2_lat", 32'(lat), 32'd2);
        chk("t2_rdata", m.rsp_rdata, 32'hDEADBEEF);
        chk("t2_err", m.rsp_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", m.rsp_valid, 1'b1);
            chk("t2_hold_rdata", m.rsp_rdata, 32'hDEADBEEF);
            chk("t2_hold_busy",  m.busy, 1'b1);
        end
        m.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t2_release", m.rsp_valid, 1'b0);
        chk("t2_ready", m.req_ready, 1'b1);

        // Range errors, aliasing and the last valid word
        txn("t3_sw0",       1'b1, 32'h0,        32'hA5A5A5A5, 1'b0, 32'h0);
        txn("t3_lw_oor",    1'b0, 32'h400,      32'h0,        1'b1, 32'h0);
        txn("t3_sw_oor",    1'b1, 32'h400,      32'h12345678, 1'b1, 32'h0);
        txn("t3_sw_nowrap", 1'b1, 32'h80000010, 32'h0000CAFE, 1'b1, 32'h0);
        txn("t3_lw0",       1'b0, 32'h0,        32'h0,        1'b0, 32'hA5A5A5A5);
        txn("t3_lw10",      1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF);
        txn("t3_sw_last",   1'b1, 32'h3FC,      32'h0BADF00D, 1'b0, 32'h0);
        txn("t3_lw_last",   1'b0, 32'h3FC,      32'h0,        1'b0, 32'h0BADF00D);

        // Misaligned store, then check what word 4 holds
        txn("t4_sw13", 1'b1, 32'h13, 32'h1, MIS_ERR, 32'h0);
        txn("t4_lw10", 1'b0, 32'h10, 32'h0, 1'b0, EXP_W4);
        txn("t4_lw12", 1'b0, 32'h12, 32'h0, MIS_ERR, MIS_ERR ? 32'h0 : EXP_W4);

        // LATENCY=1 with req_valid held high: stores then loads back-to-back
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            k = 0;
            n = 0;
            m2.req_valid = 1'b1;
            m2.req_we    = (pass == 0);
            m2.req_addr  = 32'h20;
            m2.req_wdata = 32'h100;
            while (k < 4 && n < 40) begin
                rdy = m2.req_ready;
                @(posedge clk);
                n++;
                if (rdy) begin
                    acc[k] = n;
                    k++;
                end
                @(negedge clk);
                if (rdy) begin
                    chk("t5_rsp_valid", m2.rsp_valid, 1'b1);
                    chk("t5_rsp_rdata", m2.rsp_rdata, (pass == 0) ? 32'h0 : 32'h100 + 32'(k - 1));
                    m2.req_addr  = 32'h20 + 32'(4 * k);
                    m2.req_wdata = 32'h100 + 32'(k);
                end
            end
            m2.req_valid = 1'b0;
            chk("t5_accepts", 32'(k), 32'd4);
            for (int i = 1; i < 4; i++) begin
                chk("t5_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
            end
        end

        // Reset during WAIT drops the load
        issue(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t6_busy_wait", m.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_req_ready", m.req_ready, 1'b1);
        chk("t6_busy", m.busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_rsp", m.rsp_valid, 1'b0);
            @(negedge clk);
        end
        txn("t6_lw10", 1'b0, 32'h10, 32'h0, 1'b0, EXP_W4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
